// File: rtl/input_unit_ctrl.sv
// input_unit_ctrl: unpacks UART bytes into one-bit pixels, writes them to the
// input-pixel RAM one per cycle, then serves single-bit reads until released.
module input_unit_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned NUM_PIXELS = 784,
   parameter int unsigned BYTE_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rx_rdy,
   input  logic [7:0]            i_rx_data,
   output logic                  o_clr_rx_rdy,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic                  o_ram_data,
   input  logic                  i_ram_q,
   input  logic                  i_rd_req,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic                  o_rd_valid,
   output logic                  o_rd_data,
   output logic                  o_img_ready,
   input  logic                  i_img_done
);

   // One extra bit so the pixel counter can represent NUM_PIXELS itself.
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned BIT_W = $clog2(BYTE_BITS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_READY = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_pix_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [BYTE_BITS-1:0]  r_shift;
   logic [ADDR_WIDTH-1:0] r_addr_hold;
   logic                  r_clr;
   logic                  r_rd_valid;
   logic                  r_rd_oob;

   logic                  w_last_bit;
   logic                  w_img_full;
   logic                  w_capture;
   logic                  w_rd_accept;
   logic                  w_ram_we;
   logic                  w_ram_data;
   logic [ADDR_WIDTH-1:0] w_ram_addr;

   assign w_last_bit = (r_bit_cnt == BIT_W'(BYTE_BITS - 1));
   assign w_img_full = ((r_pix_cnt + CNT_W'(1)) == CNT_W'(NUM_PIXELS));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: capture a byte, shift it out, then hold the image.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_rx_rdy) begin
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last_bit) begin
               w_next_state = w_img_full ? S_READY : S_IDLE;
            end
         end
         S_READY: begin
            if (i_img_done) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output decode: RAM port ownership per state, addr held when idle.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_data  = 1'b0;
      w_ram_addr  = r_addr_hold;
      w_capture   = 1'b0;
      w_rd_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_capture = i_rx_rdy;
         end
         S_SHIFT: begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_pix_cnt[ADDR_WIDTH-1:0];
            w_ram_data = r_shift[0];
         end
         S_READY: begin
            if (i_rd_req) begin
               w_ram_addr  = i_rd_addr;
               w_rd_accept = 1'b1;
            end
         end
         default: begin
            w_ram_we = 1'b0;
         end
      endcase
   end

   // Datapath: byte shifter, counters, ack pulse and read-return pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_addr_hold <= '0;
         r_clr       <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_oob    <= 1'b0;
      end else begin
         r_clr       <= w_capture;
         r_rd_valid  <= w_rd_accept;
         r_rd_oob    <= w_rd_accept && ({1'b0, i_rd_addr} >= CNT_W'(NUM_PIXELS));
         r_addr_hold <= w_ram_addr;
         if (w_capture) begin
            r_shift   <= i_rx_data[BYTE_BITS-1:0];
            r_bit_cnt <= '0;
         end else if (r_state == S_SHIFT) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_pix_cnt <= (w_last_bit && w_img_full) ? '0 : (r_pix_cnt + CNT_W'(1));
         end
      end
   end

   assign o_clr_rx_rdy = r_clr;
   assign o_ram_we     = w_ram_we;
   assign o_ram_addr   = w_ram_addr;
   assign o_ram_data   = w_ram_data;
   assign o_rd_valid   = r_rd_valid;
   // RAM output arrives one cycle after the address; out-of-range reads return 0.
   assign o_rd_data    = r_rd_valid & ~r_rd_oob & i_ram_q;
   assign o_img_ready  = (r_state == S_READY);

endmodule

// File: tb/tb_input_unit_ctrl.sv
// Testbench for input_unit_ctrl: random image loads, reads, release and reset,
// checked by a scoreboard against a pixel-stream reference model.
module tb_input_unit_ctrl;

   localparam int AW = 10;
   localparam int NP = 784;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_rdy = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          clr_rx_rdy;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic          ram_data;
   logic          ram_q = 1'b0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_valid;
   logic          rd_data;
   logic          img_ready;
   logic          img_done = 1'b0;

   always #5 clk = ~clk;

   input_unit_ctrl #(.ADDR_WIDTH(AW), .NUM_PIXELS(NP), .BYTE_BITS(8)) dut (
      .clk(clk), .rst(rst),
      .i_rx_rdy(rx_rdy), .i_rx_data(rx_data), .o_clr_rx_rdy(clr_rx_rdy),
      .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
      .i_ram_q(ram_q), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
      .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_img_ready(img_ready),
      .i_img_done(img_done)
   );

   // 1024x1 synchronous RAM: write-enable and registered read address.
   logic mem [1024];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: pixel stream order and the last completed image.
   typedef struct packed { logic [AW-1:0] addr; logic data; } wr_t;
   typedef struct { logic data; int cyc; } rd_t;
   wr_t  wq[$];
   rd_t  rq[$];
   logic ref_img [NP];
   logic snap    [NP];
   int   ref_pix = 0;

   task automatic push_byte(logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         ref_img[ref_pix] = b[i];
         wq.push_back('{addr: AW'(ref_pix), data: b[i]});
         ref_pix++;
      end
      if (ref_pix == NP) begin
         snap    = ref_img;
         ref_pix = 0;
      end
   endtask

   function automatic logic exp_pix(int a);
      return (a < NP) ? snap[a] : 1'b0;
   endfunction

   // Monitor: pops expected writes/reads whenever the DUT presents one.
   int   clr_count  = 0;
   logic prev_ready = 1'b0;
   logic prev_we    = 1'b0;
   int   prev_addr  = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_ready = 1'b0;
         prev_we    = 1'b0;
      end else begin
         if (clr_rx_rdy) clr_count++;
         if (ram_we) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: addr %0d data %0d, no write expected", ram_addr, ram_data);
            end else begin
               wr_t e;
               e = wq.pop_front();
               check("write_addr", int'(ram_addr), int'(e.addr));
               check("write_data", int'(ram_data), int'(e.data));
            end
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rd_valid: rd_data %0d with no read outstanding", rd_data);
            end else begin
               rd_t r;
               r = rq.pop_front();
               check("rd_data", int'(rd_data), int'(r.data));
               check("rd_latency", cyc, r.cyc + 1);
            end
         end
         if (img_ready && !prev_ready) begin
            check("ready_after_last_we", int'(prev_we), 1);
            check("ready_after_last_addr", prev_addr, NP - 1);
         end
         prev_ready = img_ready;
         prev_we    = ram_we;
         prev_addr  = int'(ram_addr);
      end
   end

   // Driver tasks assume they start 1 time unit after a rising edge.
   task automatic send_byte(logic [7:0] b);
      bit got = 0;
      rx_data = b;
      rx_rdy  = 1'b1;
      push_byte(b);
      for (int k = 0; k < 40 && !got; k++) begin
         @(posedge clk); #1;
         if (clr_rx_rdy) got = 1;
      end
      check("byte_ack", int'(got), 1);
      rx_rdy = 1'b0;
   endtask

   task automatic read_at(int a);
      rd_req  = 1'b1;
      rd_addr = AW'(a);
      rq.push_back('{data: exp_pix(a), cyc: cyc});
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200 && (wq.size() != 0 || rq.size() != 0); k++) @(negedge clk);
      check("writes_drained", wq.size(), 0);
      check("reads_drained", rq.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 200 && !img_ready; k++) @(negedge clk);
      check("img_ready_high", int'(img_ready), 1);
      @(posedge clk); #1;
   endtask

   task automatic check_zero(string tag);
      check({tag, "_clr"},   int'(clr_rx_rdy), 0);
      check({tag, "_we"},    int'(ram_we), 0);
      check({tag, "_addr"},  int'(ram_addr), 0);
      check({tag, "_data"},  int'(ram_data), 0);
      check({tag, "_valid"}, int'(rd_valid), 0);
      check({tag, "_rdata"}, int'(rd_data), 0);
      check({tag, "_ready"}, int'(img_ready), 0);
   endtask

   task automatic random_reads(int n);
      for (int i = 0; i < n; i++) begin
         read_at(int'($urandom_range(0, 1023)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      bit   acked;
      logic [7:0] b;

      // Reset and release.
      repeat (2) @(posedge clk);
      #1 check_zero("in_reset");
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check_zero("after_reset");

      // Single byte: 0xA5 -> addresses 0..7, data 1,0,1,0,0,1,0,1.
      send_byte(8'hA5);
      wait_drain();
      check("clr_pulses_one_byte", clr_count, 1);
      check("not_ready_one_byte", int'(img_ready), 0);

      // Rest of the image with rx_rdy kept busy.
      for (int i = 1; i < NP / 8; i++) send_byte(8'($urandom));
      wait_ready();
      wait_drain();

      // Back-to-back reads at the boundaries, then random reads.
      read_at(0);
      read_at(NP - 1);
      read_at(900);
      random_reads(16);
      wait_drain();

      // Pending byte in READY must not be acknowledged.
      b = 8'($urandom);
      rx_data = b;
      rx_rdy  = 1'b1;
      push_byte(b);
      acked = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (clr_rx_rdy) acked = 1;
      end
      check("no_ack_in_ready", int'(acked), 0);

      // Release together with a read; the read still returns.
      img_done = 1'b1;
      rd_req   = 1'b1;
      rd_addr  = AW'(5);
      rq.push_back('{data: exp_pix(5), cyc: cyc});
      @(posedge clk); #1;
      img_done = 1'b0;
      rd_req   = 1'b0;
      check("ready_drops_on_done", int'(img_ready), 0);
      acked = 0;
      for (int k = 0; k < 20 && !acked; k++) begin
         @(posedge clk); #1;
         if (clr_rx_rdy) acked = 1;
      end
      check("pending_byte_acked", int'(acked), 1);
      rx_rdy = 1'b0;

      // Partial reload with a stray read request, then reset mid-load.
      for (int i = 1; i < 40; i++) begin
         send_byte(8'($urandom));
         if (i == 10) begin
            rd_req  = 1'b1;
            rd_addr = AW'($urandom_range(0, 1023));
            @(posedge clk); #1;
            rd_req = 1'b0;
            @(negedge clk);
            check("no_rd_valid_before_ready", int'(rd_valid), 0);
            @(posedge clk); #1;
         end
      end
      #1 rst = 1'b1;
      wq.delete();
      rq.delete();
      ref_pix = 0;
      #1 check_zero("async_reset");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check("not_ready_after_reset", int'(img_ready), 0);

      // Fresh image from address 0, then reads and release.
      for (int i = 0; i < NP / 8; i++) send_byte(8'($urandom));
      wait_ready();
      wait_drain();
      read_at(NP - 1);
      random_reads(16);
      img_done = 1'b1;
      @(posedge clk); #1;
      img_done = 1'b0;
      check("ready_drops_final", int'(img_ready), 0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
